// File: rtl/apb4_cmd_master_pkg.sv
// Shared types and defaults for the APB4 command master.
package apb4_cmd_master_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } apb_state_e;

   localparam int unsigned DefaultTimeoutCycles = 256;

   // Counter width for a given timeout limit; a disabled timeout still needs one bit.
   function automatic int unsigned tmo_cnt_width(input int unsigned limit);
      return (limit == 0) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle shared by requesters and completers.
interface apb4_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb4_cmd_master_tmo_cnt.sv
// Clear/enable saturating counter; expire_o flags the last permitted ACCESS cycle.
module apb4_cmd_master_tmo_cnt
   import apb4_cmd_master_pkg::*;
#(
   parameter int unsigned Limit = DefaultTimeoutCycles
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CntW = tmo_cnt_width(Limit);

   if (Limit == 0) begin : g_off
      assign expire_o = 1'b0;
   end else begin : g_on
      localparam logic [CntW-1:0] Max  = CntW'(Limit);
      localparam logic [CntW-1:0] Last = CntW'(Limit - 1);

      logic [CntW-1:0] cnt_q, cnt_d;

      // Next count: clear wins, otherwise count up and stick at the limit.
      always_comb begin
         cnt_d = cnt_q;
         if (clr_i) begin
            cnt_d = '0;
         end else if (en_i && (cnt_q != Max)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Count register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign expire_o = (cnt_q == Last);
   end

endmodule

// File: rtl/apb4_cmd_master.sv
// Single-outstanding APB4 requester: valid/ready command in, valid/ready response out.
module apb4_cmd_master
   import apb4_cmd_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic                    req_write_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   apb4_if.master                  apb4
);

   apb_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] strb_q;
   logic [2:0]              prot_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;
   logic                    tmo_q;

   logic accept;
   logic xfer_ok;
   logic xfer_tmo;
   logic expire;

   // Next state and transfer events; pready takes priority over the timeout.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      xfer_ok  = 1'b0;
      xfer_tmo = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               accept  = 1'b1;
               state_d = StSetup;
            end
         end
         StSetup: state_d = StAccess;
         StAccess: begin
            if (apb4.pready) begin
               xfer_ok = 1'b1;
               state_d = StResp;
            end else if (expire) begin
               xfer_tmo = 1'b1;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // State register; reset also drops psel/penable since they decode from state.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Command registers feed the bus directly and hold between transfers.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
      end else if (accept) begin
         addr_q  <= req_addr_i;
         write_q <= req_write_i;
         wdata_q <= req_wdata_i;
         strb_q  <= req_write_i ? req_strb_i : '0;
         prot_q  <= req_prot_i;
      end
   end

   // Response registers, loaded once per transfer and held through RESP.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else if (xfer_ok) begin
         rdata_q <= write_q ? '0 : apb4.prdata;
         err_q   <= apb4.pslverr;
         tmo_q   <= 1'b0;
      end else if (xfer_tmo) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
         tmo_q   <= 1'b1;
      end
   end

   // Counter is zero on the first ACCESS cycle because it clears during SETUP.
   apb4_cmd_master_tmo_cnt #(
      .Limit (TIMEOUT_CYCLES)
   ) u_tmo_cnt (
      .clk_i    (pclk),
      .rst_ni   (presetn),
      .clr_i    (state_q == StSetup),
      .en_i     (state_q == StAccess),
      .expire_o (expire)
   );

   assign req_ready_o   = (state_q == StIdle);
   assign rsp_valid_o   = (state_q == StResp);
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = err_q;
   assign rsp_timeout_o = tmo_q;

   assign apb4.psel    = (state_q == StSetup) || (state_q == StAccess);
   assign apb4.penable = (state_q == StAccess);
   assign apb4.paddr   = addr_q;
   assign apb4.pwrite  = write_q;
   assign apb4.pwdata  = wdata_q;
   assign apb4.pstrb   = strb_q;
   assign apb4.pprot   = prot_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench: a timeline model predicts every cycle of each transaction.
module tb_apb4_cmd_master;

   localparam int unsigned TMO = 4;
   localparam int NT = 10;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   logic [2:0]  req_prot;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;

   always #5 pclk = ~pclk;

   apb4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb4 ();

   apb4_cmd_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_addr_i    (req_addr),
      .req_write_i   (req_write),
      .req_wdata_i   (req_wdata),
      .req_strb_i    (req_strb),
      .req_prot_i    (req_prot),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_timeout),
      .apb4          (apb4)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cur_p = 0;

   // Transaction table.
   logic        t_wr   [NT];
   logic [31:0] t_addr [NT];
   logic [31:0] t_wdata[NT];
   logic [3:0]  t_strb [NT];
   logic [2:0]  t_prot [NT];
   int          t_wait [NT];
   logic        t_err  [NT];
   logic [31:0] t_rdata[NT];
   int          t_hold [NT];
   int          t_gap  [NT];
   bit          t_rst  [NT];

   // Predicted timeline (periods are counted in rising edges since time 0).
   int t_s[NT], t_e[NT], t_a[NT], t_acc_last[NT], t_resp_last[NT];
   bit t_tmo[NT];

   // What the DUT actually showed, for the literal pins at the end.
   int          acc_cnt [NT];
   int          setup_at[NT];
   logic [31:0] rdata_at[NT];
   logic        tmo_at  [NT];

   // Bus fields expected to be held on the APB.
   logic [31:0] eb_addr, eb_wdata;
   logic        eb_wr;
   logic [3:0]  eb_strb;
   logic [2:0]  eb_prot;

   int ph, k, rel_at, last_p, idle_from;
   logic dr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (period %0d)", name, act, exp, cur_p);
      end
   endtask

   task automatic set_txn(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, input int wt, input logic serr,
                          input logic [31:0] rdata, input int hold, input int gap,
                          input bit rst);
      t_wr[i] = wr; t_addr[i] = addr; t_wdata[i] = wdata; t_strb[i] = strb;
      t_prot[i] = prot; t_wait[i] = wt; t_err[i] = serr; t_rdata[i] = rdata;
      t_hold[i] = hold; t_gap[i] = gap; t_rst[i] = rst;
   endtask

   // 0 idle, 1 setup, 2 access, 3 response; idx is the owning transaction.
   function automatic int phase_of(input int p, output int idx);
      idx = -1;
      for (int i = 0; i < NT; i++) begin
         if (p == t_e[i]) begin
            idx = i;
            return 1;
         end
         if (p > t_e[i] && p <= t_acc_last[i]) begin
            idx = i;
            return 2;
         end
         if (!t_rst[i] && p > t_acc_last[i] && p <= t_resp_last[i]) begin
            idx = i;
            return 3;
         end
      end
      return 0;
   endfunction

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
      apb4.pready = 1'b0; apb4.prdata = '0; apb4.pslverr = 1'b0;
      eb_addr = '0; eb_wdata = '0; eb_wr = 1'b0; eb_strb = '0; eb_prot = '0;
      rel_at = -1;

      //        k  wr    addr          wdata         strb  prot wait err   rdata        hold gap rst
      set_txn(0, 1'b1, 32'h0000_0008, 32'h0000_00A5, 4'hF, 3'd0, 0, 1'b0, 32'h0,         0, 0, 0);
      set_txn(1, 1'b0, 32'h0000_0010, 32'hFFFF_0000, 4'hF, 3'd1, 3, 1'b0, 32'h1234_5678, 0, 1, 0);
      set_txn(2, 1'b1, 32'h0000_0014, 32'h0000_BEEF, 4'h3, 3'd2, 1, 1'b1, 32'hFFFF_FFFF, 1, 1, 0);
      set_txn(3, 1'b0, 32'h0000_0018, 32'h0,         4'h0, 3'd0, 10, 1'b0, 32'hDEAD_BEEF, 0, 1, 0);
      set_txn(4, 1'b0, 32'h0000_001C, 32'h0,         4'h5, 3'd3, 3, 1'b0, 32'hCAFE_F00D, 0, 2, 0);
      set_txn(5, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hC, 3'd0, 0, 1'b0, 32'h0,         5, 1, 0);
      set_txn(6, 1'b0, 32'h0000_0024, 32'h0,         4'hF, 3'd4, 0, 1'b0, 32'h0BAD_F00D, 0, 2, 0);
      set_txn(7, 1'b1, 32'h0000_0028, 32'h0000_0055, 4'hF, 3'd6, 20, 1'b0, 32'h0,        0, 3, 1);
      set_txn(8, 1'b1, 32'h0000_002C, 32'h0000_0066, 4'hF, 3'd0, 2, 1'b0, 32'h0,         0, 10, 0);
      set_txn(9, 1'b0, 32'h0000_0030, 32'h0,         4'hF, 3'd5, 0, 1'b1, 32'h0000_5A5A, 0, 1, 0);

      // Timeline from the protocol rules: accept on the first edge seen in IDLE with valid up,
      // one SETUP cycle, wait+1 ACCESS cycles capped at TMO, then RESP until rsp_ready.
      idle_from = 2;
      for (int i = 0; i < NT; i++) begin
         t_s[i] = (i == 0) ? 2 : t_e[i-1] + t_gap[i];
         t_e[i] = ((t_s[i] > idle_from) ? t_s[i] : idle_from) + 1;
         t_tmo[i] = (t_wait[i] >= int'(TMO));
         t_a[i] = t_tmo[i] ? int'(TMO) : t_wait[i] + 1;
         if (t_rst[i]) begin
            t_acc_last[i]  = t_e[i] + 2;
            t_resp_last[i] = t_acc_last[i];
            idle_from      = t_acc_last[i] + 2;
         end else begin
            t_acc_last[i]  = t_e[i] + t_a[i];
            t_resp_last[i] = t_acc_last[i] + 1 + t_hold[i];
            idle_from      = t_resp_last[i] + 1;
         end
         acc_cnt[i] = 0; setup_at[i] = -1; rdata_at[i] = 'x; tmo_at[i] = 1'bx;
      end
      last_p = idle_from + 3;

      // Reset state, sampled while presetn is still low.
      @(negedge pclk);
      cur_p = 1;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset psel", 32'(apb4.psel), 32'd0);
      chk("reset penable", 32'(apb4.penable), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      chk("reset rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset paddr", apb4.paddr, 32'd0);
      chk("reset pwrite", 32'(apb4.pwrite), 32'd0);
      chk("reset pstrb", 32'(apb4.pstrb), 32'd0);
      presetn = 1'b1;

      for (int p = 2; p <= last_p; p++) begin
         @(negedge pclk);
         cur_p = p;
         ph = phase_of(p, k);

         // Compare against the model.
         if (ph == 1) begin
            eb_addr = t_addr[k]; eb_wdata = t_wdata[k]; eb_wr = t_wr[k];
            eb_strb = t_wr[k] ? t_strb[k] : 4'h0; eb_prot = t_prot[k];
         end
         chk("req_ready", 32'(req_ready), 32'(ph == 0));
         chk("psel", 32'(apb4.psel), 32'(ph == 1 || ph == 2));
         chk("penable", 32'(apb4.penable), 32'(ph == 2));
         chk("rsp_valid", 32'(rsp_valid), 32'(ph == 3));
         chk("paddr", apb4.paddr, eb_addr);
         chk("pwrite", 32'(apb4.pwrite), 32'(eb_wr));
         chk("pwdata", apb4.pwdata, eb_wdata);
         chk("pstrb", 32'(apb4.pstrb), 32'(eb_strb));
         chk("pprot", 32'(apb4.pprot), 32'(eb_prot));
         if (ph == 3) begin
            chk("rsp_rdata", rsp_rdata, (t_wr[k] || t_tmo[k]) ? 32'h0 : t_rdata[k]);
            chk("rsp_err", 32'(rsp_err), 32'(t_tmo[k] | t_err[k]));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(t_tmo[k]));
         end

         // Observations for the literal pins.
         if (ph != 0) begin
            if (apb4.penable) acc_cnt[k]++;
            if (apb4.psel && !apb4.penable) setup_at[k] = p;
            if (rsp_valid) begin
               rdata_at[k] = rsp_rdata;
               tmo_at[k]   = rsp_timeout;
            end
         end

         if (p == rel_at) presetn = 1'b1;

         // Drive inputs for this period.
         req_valid = 1'b0;
         for (int i = 0; i < NT; i++) begin
            if (t_s[i] <= p && p < t_e[i]) begin
               req_valid = 1'b1; req_write = t_wr[i]; req_addr = t_addr[i];
               req_wdata = t_wdata[i]; req_strb = t_strb[i]; req_prot = t_prot[i];
            end
         end
         dr = (ph == 2) && !t_tmo[k] && (p == t_e[k] + 1 + t_wait[k]);
         apb4.pready  = dr;
         apb4.prdata  = dr ? t_rdata[k] : (32'hA5A5_0000 | 32'(p));
         apb4.pslverr = dr ? t_err[k] : (ph == 2);
         rsp_ready    = (ph == 3) && (p == t_resp_last[k]);

         // Reset pulse in the middle of an ACCESS cycle.
         if (ph == 2 && t_rst[k] && p == t_acc_last[k]) begin
            #2 presetn = 1'b0;
            #1;
            chk("async rst psel", 32'(apb4.psel), 32'd0);
            chk("async rst penable", 32'(apb4.penable), 32'd0);
            chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
            chk("async rst paddr", apb4.paddr, 32'd0);
            eb_addr = '0; eb_wdata = '0; eb_wr = 1'b0; eb_strb = '0; eb_prot = '0;
            apb4.pready = 1'b0;
            rel_at = p + 1;
         end
      end

      // Hand-computed pins on what the DUT showed.
      chk("txn0 setup period", 32'(setup_at[0]), 32'd3);
      chk("txn0 access cycles", 32'(acc_cnt[0]), 32'd1);
      chk("txn0 rdata", rdata_at[0], 32'h0);
      chk("txn1 access cycles", 32'(acc_cnt[1]), 32'd4);
      chk("txn1 rdata", rdata_at[1], 32'h1234_5678);
      chk("txn2 access cycles", 32'(acc_cnt[2]), 32'd2);
      chk("txn3 access cycles", 32'(acc_cnt[3]), 32'd4);
      chk("txn3 timeout", 32'(tmo_at[3]), 32'd1);
      chk("txn3 rdata", rdata_at[3], 32'h0);
      chk("txn4 access cycles", 32'(acc_cnt[4]), 32'd4);
      chk("txn4 timeout", 32'(tmo_at[4]), 32'd0);
      chk("txn4 rdata", rdata_at[4], 32'hCAFE_F00D);
      chk("txn6 after backpressure", 32'(setup_at[6] - setup_at[5]), 32'd9);
      chk("txn7 access before reset", 32'(acc_cnt[7]), 32'd2);
      chk("txn9 rdata", rdata_at[9], 32'h0000_5A5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
